// File: rtl/cnt_checker_if.sv
// Sample/result bundle for the counter checker. The checker uses the slave
// view; whatever feeds it samples uses the master view.
interface cnt_checker_if;
  logic       en;
  logic [3:0] cnt;
  logic       clr_err;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic [3:0] exp;
  logic [1:0] state;

  modport master (output en, cnt, clr_err,
                  input  locked, err, wrap, err_cnt, exp, state);
  modport slave  (input  en, cnt, clr_err,
                  output locked, err, wrap, err_cnt, exp, state);
endinterface

// File: rtl/cnt_checker.sv
// Tracks a free-running counter. It locks after LOCK_LEN consecutive good steps
// and drops lock after MISS_LIMIT consecutive bad steps. Every output is a flop.
module cnt_checker #(
  parameter int LOCK_LEN   = 3,
  parameter int MAX_VAL    = 15,
  parameter int MISS_LIMIT = 2
) (
  input logic          clk,
  input logic          rst,
  cnt_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT = 2'b00, SYNC = 2'b01, LOCKED = 2'b10, BAD = 2'b11} state_t;

  state_t     state_q, state_d;
  logic [3:0] exp_q, exp_d, run_q, run_d, miss_q, miss_d;
  logic [7:0] ecnt_q, ecnt_d;
  logic       err_q, err_d, wrap_q, wrap_d, locked_q;
  logic       match;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    return (v >= 4'(MAX_VAL)) ? 4'd0 : v + 4'd1;
  endfunction

  // A sample above MAX_VAL can never match, whatever the value of exp_q.
  assign match = (bus.cnt == exp_q) && (bus.cnt <= 4'(MAX_VAL));

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    ecnt_d  = bus.clr_err ? 8'd0 : ecnt_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (state_q == BAD) begin
      state_d = HUNT;
    end else if (bus.en) begin
      exp_d = nxt(bus.cnt);
      unique case (state_q)
        HUNT: begin
          run_d   = 4'd1;
          state_d = SYNC;
        end
        SYNC: begin
          if (match) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == 4'(LOCK_LEN)) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            run_d = 4'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_d = 4'd0;
            wrap_d = (bus.cnt == 4'd0);
          end else begin
            err_d  = 1'b1;
            // A clear on the same edge still counts this mismatch.
            ecnt_d = bus.clr_err ? 8'd1 : (ecnt_q == 8'hff) ? 8'hff : ecnt_q + 8'd1;
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == 4'(MISS_LIMIT)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      exp_q    <= 4'd0;
      run_q    <= 4'd0;
      miss_q   <= 4'd0;
      ecnt_q   <= 8'd0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      ecnt_q   <= ecnt_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  assign bus.state   = state_q;
  assign bus.exp     = exp_q;
  assign bus.err_cnt = ecnt_q;
  assign bus.err     = err_q;
  assign bus.wrap    = wrap_q;
  assign bus.locked  = locked_q;
endmodule

// File: tb/tb_cnt_checker.sv
// Directed and random stimulus for cnt_checker. Each output is compared with a
// behavioural model kept inside the bench.
module tb_cnt_checker;
  localparam int LOCK_LEN = 3, MAX_VAL = 15, MISS_LIMIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnt_checker_if bus ();
  cnt_checker #(.LOCK_LEN(LOCK_LEN), .MAX_VAL(MAX_VAL), .MISS_LIMIT(MISS_LIMIT))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0;
  // model: mode 0 hunting, 1 syncing, 2 locked
  int m_mode = 0, m_exp = 0, m_run = 0, m_miss = 0, m_ecnt = 0;
  int m_err = 0, m_wrap = 0;

  function automatic int nxt(input int v);
    return (v >= MAX_VAL) ? 0 : v + 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"},  int'(bus.state),   m_mode);
    chk({tag, ".locked"}, int'(bus.locked),  (m_mode == 2) ? 1 : 0);
    chk({tag, ".err"},    int'(bus.err),     m_err);
    chk({tag, ".wrap"},   int'(bus.wrap),    m_wrap);
    chk({tag, ".errcnt"}, int'(bus.err_cnt), m_ecnt);
    chk({tag, ".exp"},    int'(bus.exp),     m_exp);
  endtask

  // Apply one cycle of inputs, advance the model, check the outputs.
  task automatic step(input string tag, input bit e, input int c, input bit clr, input bit r);
    bit good;
    rst = r; bus.en = e; bus.cnt = 4'(c); bus.clr_err = clr;
    @(posedge clk);
    m_err = 0; m_wrap = 0;
    if (r) begin
      m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_ecnt = 0;
    end else begin
      if (clr) m_ecnt = 0;
      if (e) begin
        good = (c <= MAX_VAL) && (c == m_exp);
        if (m_mode == 0) begin
          m_run = 1; m_mode = 1;
        end else if (m_mode == 1) begin
          m_run = good ? m_run + 1 : 1;
          if (m_run == LOCK_LEN) begin m_mode = 2; m_miss = 0; end
        end else if (good) begin
          m_miss = 0; m_wrap = (c == 0) ? 1 : 0;
        end else begin
          m_err = 1;
          m_ecnt = (m_ecnt >= 255) ? 255 : m_ecnt + 1;
          m_miss++;
          if (m_miss == MISS_LIMIT) m_mode = 0;
        end
        m_exp = nxt(c);
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.cnt = 4'd0; bus.clr_err = 1'b0;
    // Reset also wins over en and clr_err.
    step("rst", 1, 7, 1, 1);
    chk("rst_state", int'(bus.state), 0);

    // Count up from 0: the checker locks after the third sample.
    for (int v = 0; v < 3; v++) step("lock", 1, v, 0, 0);
    chk("lock_done", int'(bus.locked), 1);

    // Continue counting through 15 -> 0 -> 1; exactly one wrap pulse.
    for (int v = 3; v <= 17; v++) begin
      step("wrap", 1, v % 16, 0, 0);
      if (v == 16) chk("wrap_pulse", int'(bus.wrap), 1);
    end
    chk("wrap_exp", int'(bus.exp), 2);

    // Single miss then recovery: expected 5, feed 9 then 10.
    for (int v = 2; v <= 4; v++) step("pre5", 1, v, 0, 0);
    step("miss1", 1, 9, 0, 0);
    chk("miss1_err", int'(bus.err), 1);
    step("recov", 1, 10, 0, 0);
    chk("recov_lock", int'(bus.locked), 1);
    chk("recov_exp", int'(bus.exp), 11);

    // Two consecutive misses force hunting; three correct samples relock.
    step("miss_a", 1, 9, 0, 0);
    step("miss_b", 1, 3, 0, 0);
    chk("drop_state", int'(bus.state), 0);
    chk("drop_cnt", int'(bus.err_cnt), 3);
    for (int v = 4; v <= 6; v++) step("relock", 1, v, 0, 0);
    chk("relock", int'(bus.locked), 1);

    // Bring the error count to 7, then clear on the same edge as a miss.
    while (m_ecnt < 7) begin
      step("to7_miss", 1, (m_exp + 3) % 16, 0, 0);
      step("to7_hit", 1, m_exp, 0, 0);
    end
    chk("at7", int'(bus.err_cnt), 7);
    step("clr_miss", 1, (m_exp + 3) % 16, 1, 0);
    chk("clr_miss_cnt", int'(bus.err_cnt), 1);
    chk("clr_miss_err", int'(bus.err), 1);
    step("clr_hit", 1, m_exp, 0, 0);

    // Drive the count into saturation and past it.
    for (int i = 0; i < 260; i++) begin
      step("sat_miss", 1, (m_exp + 5) % 16, 0, 0);
      step("sat_hit", 1, m_exp, 0, 0);
    end
    chk("sat_cnt", int'(bus.err_cnt), 255);
    step("sat_more", 1, (m_exp + 5) % 16, 0, 0);
    chk("sat_err", int'(bus.err), 1);

    // Reset mid-lock, then enable gaps inside the lock sequence.
    step("rst_mid", 1, m_exp, 0, 1);
    chk("rst_mid_lock", int'(bus.locked), 0);
    step("en4", 1, 4, 0, 0);
    step("gap1", 0, $urandom_range(0, 15), 0, 0);
    step("gap2", 0, $urandom_range(0, 15), 0, 0);
    step("en5", 1, 5, 0, 0);
    chk("en5_notlock", int'(bus.locked), 0);
    step("en6", 1, 6, 0, 0);
    chk("en6_lock", int'(bus.locked), 1);

    // Random traffic, mostly following the expected value.
    for (int i = 0; i < 4000; i++) begin
      bit e, clr, r;
      int c;
      e   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : m_exp;
      clr = e && ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 250) == 0);
      step("rand", e, c, clr, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
